// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: EX->MEM and MEM->WB bundles, FSM state and
// the data-memory request view.
package mem_stage_pkg;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic is_branch;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       control;
        logic [4:0]  reg_rd_id;
        logic [31:0] alu_data;
        logic [31:0] memory_data;
        logic [31:0] pc_branch;
        logic        partial_zero_flag;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t       control;
        logic [4:0]  reg_rd_id;
        logic [31:0] alu_data;
        logic [31:0] memory_data;
    } mem_wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// Bus transaction watchdog: cleared on entry to a transaction, counts while
// enabled, flags expiry once the count reaches TIMEOUT_CYCLES-1.
module mem_bus_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMER_W        = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !expired)
            count <= count + 1'b1;
    end

    assign expired = en && (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word loads/stores over a valid/ready port, branch
// resolution register, and back-pressure to EX while a transaction is open.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMER_W        = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ex_mem_t     ex_mem_in,
    input  logic        ex_mem_valid,
    output logic        ex_mem_ready,
    input  logic        flush,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output mem_wb_t     mem_wb_out,
    output logic        mem_wb_valid,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        misaligned,
    output logic        bus_error
);

    mem_state_t state;
    ex_mem_t    hold;
    logic       kill;
    logic       accept, is_mem_in, mis_in;
    logic       store_done, load_done, tmr_expired;
    ctrl_t      mis_ctrl;
    dmem_req_t  req;

    assign accept     = ex_mem_valid && (state == IDLE) && !flush;
    assign is_mem_in  = ex_mem_in.control.mem_read || ex_mem_in.control.mem_write;
    assign mis_in     = is_misaligned(ex_mem_in.alu_data);
    assign store_done = (state == REQ) && dmem_req_ready && hold.control.mem_write;
    assign load_done  = (state == RESP) && dmem_rsp_valid;

    always_comb begin
        mis_ctrl           = ex_mem_in.control;
        mis_ctrl.reg_write = 1'b0;
    end

    // Both mem_read and mem_write set resolves to a store through mem_write.
    assign req = '{we:    hold.control.mem_write,
                   addr:  {hold.alu_data[31:2], hold.alu_data[1:0] & ~WORD_ALIGN_MASK},
                   wdata: hold.memory_data};

    assign ex_mem_ready   = (state == IDLE);
    assign dmem_req_valid = (state == REQ);
    assign dmem_we        = req.we;
    assign dmem_addr      = req.addr;
    assign dmem_wdata     = req.wdata;

    mem_bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMER_W       (TIMER_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept && is_mem_in && !mis_in),
        .en     (state != IDLE),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold          <= '0;
            kill          <= 1'b0;
            mem_wb_out    <= '0;
            mem_wb_valid  <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            misaligned    <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            mem_wb_valid <= 1'b0;
            branch_taken <= 1'b0;
            misaligned   <= 1'b0;
            unique case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (accept) begin
                        branch_taken  <= ex_mem_in.control.is_branch && ex_mem_in.partial_zero_flag;
                        branch_target <= ex_mem_in.pc_branch;
                        if (!is_mem_in) begin
                            mem_wb_valid <= 1'b1;
                            mem_wb_out   <= '{control: ex_mem_in.control, reg_rd_id: ex_mem_in.reg_rd_id,
                                              alu_data: ex_mem_in.alu_data, memory_data: 32'h0};
                        end else if (mis_in) begin
                            misaligned   <= 1'b1;
                            mem_wb_valid <= 1'b1;
                            mem_wb_out   <= '{control: mis_ctrl, reg_rd_id: ex_mem_in.reg_rd_id,
                                              alu_data: ex_mem_in.alu_data, memory_data: 32'h0};
                        end else begin
                            hold  <= ex_mem_in;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    kill <= kill || flush;
                    if (store_done) begin
                        if (!(kill || flush)) begin
                            mem_wb_valid <= 1'b1;
                            mem_wb_out   <= '{control: hold.control, reg_rd_id: hold.reg_rd_id,
                                              alu_data: hold.alu_data, memory_data: 32'h0};
                        end
                        state <= IDLE;
                        kill  <= 1'b0;
                    end else if (tmr_expired) begin
                        bus_error <= 1'b1;
                        state     <= IDLE;
                        kill      <= 1'b0;
                    end else if (dmem_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    kill <= kill || flush;
                    if (load_done) begin
                        if (!(kill || flush)) begin
                            mem_wb_valid <= 1'b1;
                            mem_wb_out   <= '{control: hold.control, reg_rd_id: hold.reg_rd_id,
                                              alu_data: hold.alu_data, memory_data: dmem_rdata};
                        end
                        state <= IDLE;
                        kill  <= 1'b0;
                    end else if (tmr_expired) begin
                        bus_error <= 1'b1;
                        state     <= IDLE;
                        kill      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB bundles are queued at issue and
// compared by an independent monitor on every mem_wb_valid pulse.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 8;

    localparam ctrl_t C_ADD = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0, is_branch: 1'b0};
    localparam ctrl_t C_BR  = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0, is_branch: 1'b1};
    localparam ctrl_t C_LD  = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1, mem_write: 1'b0, is_branch: 1'b0};
    localparam ctrl_t C_LDM = '{reg_write: 1'b0, mem_to_reg: 1'b1, mem_read: 1'b1, mem_write: 1'b0, is_branch: 1'b0};
    localparam ctrl_t C_ST  = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b1, is_branch: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ex_mem_t     ex_mem_in = '0;
    logic        ex_mem_valid = 1'b0;
    logic        ex_mem_ready;
    logic        flush = 1'b0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    mem_wb_t     mem_wb_out;
    logic        mem_wb_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        misaligned;
    logic        bus_error;

    int vectors = 0;
    int miscompares = 0;
    mem_wb_t sb[$];

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO), .TIMER_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .ex_mem_in(ex_mem_in), .ex_mem_valid(ex_mem_valid),
        .ex_mem_ready(ex_mem_ready), .flush(flush), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .mem_wb_out(mem_wb_out), .mem_wb_valid(mem_wb_valid), .branch_taken(branch_taken),
        .branch_target(branch_target), .misaligned(misaligned), .bus_error(bus_error)
    );

    function automatic ex_mem_t mk(ctrl_t c, logic [4:0] rd, logic [31:0] alu,
                                   logic [31:0] md, logic [31:0] pc, logic z);
        return '{control: c, reg_rd_id: rd, alu_data: alu, memory_data: md,
                 pc_branch: pc, partial_zero_flag: z};
    endfunction

    function automatic mem_wb_t wb(ctrl_t c, logic [4:0] rd, logic [31:0] alu, logic [31:0] md);
        return '{control: c, reg_rd_id: rd, alu_data: alu, memory_data: md};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input ex_mem_t x);
        ex_mem_in    = x;
        ex_mem_valid = 1'b1;
        tick();
        ex_mem_valid = 1'b0;
    endtask

    // Monitor: every retire pulse must match the oldest queued expectation.
    initial begin
        mem_wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_wb_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL wb_unexpected: got %0h expected no retire at %0t", mem_wb_out, $time);
                end else begin
                    e = sb.pop_front();
                    if (mem_wb_out !== e) begin
                        miscompares++;
                        $display("FAIL wb_bundle: got %0h expected %0h at %0t", mem_wb_out, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_wb_valid", 128'(mem_wb_valid), 128'(0));
        chk("rst_wb_out", 128'(mem_wb_out), 128'(0));
        chk("rst_req_valid", 128'(dmem_req_valid), 128'(0));
        chk("rst_bus_error", 128'(bus_error), 128'(0));
        chk("rst_ready", 128'(ex_mem_ready), 128'(1));
        rst_n = 1'b1;
        tick();

        // ADD: memory_data on the input must be dropped
        sb.push_back(wb(C_ADD, 5'd5, 32'h10, 32'h0));
        offer(mk(C_ADD, 5'd5, 32'h10, 32'hAAAA_5555, 32'h0, 1'b0));
        chk("add_wb_valid", 128'(mem_wb_valid), 128'(1));
        chk("add_ready", 128'(ex_mem_ready), 128'(1));
        chk("add_no_req", 128'(dmem_req_valid), 128'(0));

        // Branch taken, then not taken
        sb.push_back(wb(C_BR, 5'd0, 32'h0, 32'h0));
        offer(mk(C_BR, 5'd0, 32'h0, 32'h0, 32'h80, 1'b1));
        chk("br_taken", 128'(branch_taken), 128'(1));
        chk("br_target", 128'(branch_target), 128'(32'h80));
        tick();
        chk("br_pulse_end", 128'(branch_taken), 128'(0));
        sb.push_back(wb(C_BR, 5'd0, 32'h0, 32'h0));
        offer(mk(C_BR, 5'd0, 32'h0, 32'h0, 32'h90, 1'b0));
        chk("br_not_taken", 128'(branch_taken), 128'(0));
        chk("br_target2", 128'(branch_target), 128'(32'h90));

        // Load 0x100: ready at N+1, rsp at N+3, retire at N+4
        sb.push_back(wb(C_LD, 5'd7, 32'h100, 32'hDEAD_BEEF));
        offer(mk(C_LD, 5'd7, 32'h100, 32'h0, 32'h0, 1'b0));
        dmem_req_ready = 1'b1;
        chk("ld_req_valid", 128'(dmem_req_valid), 128'(1));
        chk("ld_addr", 128'(dmem_addr), 128'(32'h100));
        chk("ld_we", 128'(dmem_we), 128'(0));
        chk("ld_ready_n1", 128'(ex_mem_ready), 128'(0));
        tick();
        dmem_req_ready = 1'b0;
        chk("ld_ready_n2", 128'(ex_mem_ready), 128'(0));
        chk("ld_req_dropped", 128'(dmem_req_valid), 128'(0));
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hDEAD_BEEF;
        chk("ld_ready_n3", 128'(ex_mem_ready), 128'(0));
        chk("ld_no_early_wb", 128'(mem_wb_valid), 128'(0));
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        chk("ld_wb_n4", 128'(mem_wb_valid), 128'(1));
        chk("ld_ready_n4", 128'(ex_mem_ready), 128'(1));

        // Store 0x204 with ready held low for 3 cycles
        sb.push_back(wb(C_ST, 5'd3, 32'h204, 32'h0));
        offer(mk(C_ST, 5'd3, 32'h204, 32'h1234_5678, 32'h0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            chk("st_req_valid", 128'(dmem_req_valid), 128'(1));
            chk("st_addr", 128'(dmem_addr), 128'(32'h204));
            chk("st_wdata", 128'(dmem_wdata), 128'(32'h1234_5678));
            chk("st_we", 128'(dmem_we), 128'(1));
            tick();
        end
        dmem_req_ready = 1'b1;
        chk("st_addr_hs", 128'(dmem_addr), 128'(32'h204));
        chk("st_no_early_wb", 128'(mem_wb_valid), 128'(0));
        tick();
        dmem_req_ready = 1'b0;
        chk("st_wb", 128'(mem_wb_valid), 128'(1));
        chk("st_ready", 128'(ex_mem_ready), 128'(1));

        // Misaligned load 0x102
        sb.push_back(wb(C_LDM, 5'd9, 32'h102, 32'h0));
        offer(mk(C_LD, 5'd9, 32'h102, 32'h0, 32'h0, 1'b0));
        chk("mis_pulse", 128'(misaligned), 128'(1));
        chk("mis_no_req", 128'(dmem_req_valid), 128'(0));
        chk("mis_wb", 128'(mem_wb_valid), 128'(1));
        tick();
        chk("mis_pulse_end", 128'(misaligned), 128'(0));
        chk("mis_no_req2", 128'(dmem_req_valid), 128'(0));

        // Flush during RESP: response arrives, no retire
        offer(mk(C_LD, 5'd4, 32'h400, 32'h0, 32'h0, 1'b0));
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hCAFE_F00D;
        chk("fl_still_busy", 128'(ex_mem_ready), 128'(0));
        tick();
        dmem_rsp_valid = 1'b0;
        chk("fl_no_wb", 128'(mem_wb_valid), 128'(0));
        chk("fl_ready", 128'(ex_mem_ready), 128'(1));
        sb.push_back(wb(C_ADD, 5'd6, 32'h66, 32'h0));
        offer(mk(C_ADD, 5'd6, 32'h66, 32'h0, 32'h0, 1'b0));
        chk("fl_kill_cleared", 128'(mem_wb_valid), 128'(1));

        // Timeout: load never answered
        offer(mk(C_LD, 5'd8, 32'h300, 32'h0, 32'h0, 1'b0));
        chk("to_n1_err", 128'(bus_error), 128'(0));
        for (int i = 2; i <= TO; i++) begin
            tick();
            chk("to_err_early", 128'(bus_error), 128'(0));
            chk("to_busy", 128'(ex_mem_ready), 128'(0));
        end
        tick();
        chk("to_err_set", 128'(bus_error), 128'(1));
        chk("to_ready", 128'(ex_mem_ready), 128'(1));
        chk("to_no_req", 128'(dmem_req_valid), 128'(0));
        repeat (3) tick();
        chk("to_err_sticky", 128'(bus_error), 128'(1));

        // Async reset mid-REQ
        sb.push_back(wb(C_BR, 5'd0, 32'h0, 32'h0));
        offer(mk(C_BR, 5'd0, 32'h0, 32'h0, 32'hC0, 1'b1));
        offer(mk(C_ST, 5'd2, 32'h500, 32'h5555_AAAA, 32'h0, 1'b0));
        chk("rr_req_valid", 128'(dmem_req_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req_valid0", 128'(dmem_req_valid), 128'(0));
        chk("rr_wb_out0", 128'(mem_wb_out), 128'(0));
        chk("rr_target0", 128'(branch_target), 128'(0));
        chk("rr_bus_error0", 128'(bus_error), 128'(0));
        chk("rr_ready", 128'(ex_mem_ready), 128'(1));
        #2 rst_n = 1'b1;
        tick();

        sb.push_back(wb(C_ADD, 5'd11, 32'hB0, 32'h0));
        offer(mk(C_ADD, 5'd11, 32'hB0, 32'h0, 32'h0, 1'b0));
        chk("post_rst_wb", 128'(mem_wb_valid), 128'(1));
        repeat (3) tick();
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
